// File: rtl/window_buffer.sv
// -----------------------------------------------------------------------------
// window_buffer
// Sliding WIN x WIN neighbourhood generator for a raster pixel stream.
// WIN-1 line memories of IMG_W pixels each feed a WIN x WIN window register.
// A frame-position FSM (IDLE / FILL / STREAM) tracks the row and column of
// every accepted pixel and decides when a complete window exists.
//
// Optional feature (macro WINBUF_EDGE_ZERO_EN):
//   When defined, windows are also presented for columns 0..WIN-2 of each
//   streaming row. Window columns that would wrap onto the previous line
//   are forced to zero.
//
// Parameters:
//   DATA_W  pixel width
//   WIN     window edge (odd, 3..9)
//   IMG_W   pixels per line (>= WIN)
//   IMG_H   lines per frame (>= WIN)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   data_enable   pixel valid, accepted every cycle it is high
//   sof           start of frame, marks pixel (0,0), qualified by data_enable
//   data_in       input pixel
//   window_out    WIN*WIN pixels, row-major, top-left in the MSBs
//   window_valid  one-cycle pulse: window/center/coordinates are valid
//   center_out    window element (WIN/2, WIN/2)
//   out_row       row of the window's bottom-right pixel
//   out_col       column of the window's bottom-right pixel
//   frame_done    one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_buffer #(
    parameter int DATA_W = 8,
    parameter int WIN    = 7,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_enable,
    input  logic                          sof,
    input  logic [DATA_W-1:0]             data_in,
    output logic [WIN*WIN*DATA_W-1:0]     window_out,
    output logic                          window_valid,
    output logic [DATA_W-1:0]             center_out,
    output logic [$clog2(IMG_H)-1:0]      out_row,
    output logic [$clog2(IMG_W)-1:0]      out_col,
    output logic                          frame_done
);

    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int CTR    = WIN / 2;
    localparam int FLAT_W = WIN * WIN * DATA_W;

`ifdef WINBUF_EDGE_ZERO_EN
    localparam bit EDGE_ZERO = 1'b1;
`else
    localparam bit EDGE_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ROW_W-1:0]   row_r;
    logic [ROW_W-1:0]   row_nxt_s;
    logic [ROW_W-1:0]   pix_row_s;
    logic [COL_W-1:0]   col_r;
    logic [COL_W-1:0]   col_nxt_s;
    logic [COL_W-1:0]   pix_col_s;
    logic               accept_s;
    logic               last_s;
    logic               valid_s;

    // Line memory k+1 lives at index k; element IMG_W-1 is its output tap.
    logic [DATA_W-1:0]  lm_r      [WIN-1][IMG_W];
    logic [DATA_W-1:0]  win_r     [WIN][WIN];
    logic [DATA_W-1:0]  win_nxt_s [WIN][WIN];
    logic [FLAT_W-1:0]  win_flat_s;
    logic [DATA_W-1:0]  center_s;

    // Acceptance, pixel position, next-state and next-counter decode
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        valid_s     = 1'b0;
        pix_row_s   = row_r;
        pix_col_s   = col_r;

        case (state_r)
            ST_IDLE:   accept_s = data_enable & sof;
            ST_FILL:   accept_s = data_enable;
            ST_STREAM: accept_s = data_enable;
            default:   accept_s = 1'b0;
        endcase

        // A sof pixel is always (0,0), whatever the counters say.
        if (sof) begin
            pix_row_s = {ROW_W{1'b0}};
            pix_col_s = {COL_W{1'b0}};
        end else begin
            pix_row_s = row_r;
            pix_col_s = col_r;
        end

        if (accept_s) begin
            last_s = !sof && (pix_row_s == ROW_W'(IMG_H - 1))
                          && (pix_col_s == COL_W'(IMG_W - 1));
            // STREAM implies row >= WIN-1; a sof pixel always reopens FILL.
            valid_s = (state_r == ST_STREAM) && !sof
                      && (EDGE_ZERO || (pix_col_s >= COL_W'(WIN - 1)));
            if (last_s) begin
                row_nxt_s   = {ROW_W{1'b0}};
                col_nxt_s   = {COL_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end else begin
                if (pix_col_s == COL_W'(IMG_W - 1)) begin
                    col_nxt_s = {COL_W{1'b0}};
                    row_nxt_s = pix_row_s + ROW_W'(1);
                end else begin
                    col_nxt_s = pix_col_s + COL_W'(1);
                    row_nxt_s = pix_row_s;
                end
                if (row_nxt_s >= ROW_W'(WIN - 1)) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and position counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            row_r   <= {ROW_W{1'b0}};
            col_r   <= {COL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
        end
    end

    // Line memories: a chain of IMG_W-deep shift registers, not cleared
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lm_r[0][0] <= data_in;
            for (int k = 1; k < WIN - 1; k++) begin
                lm_r[k][0] <= lm_r[k-1][IMG_W-1];
            end
            for (int k = 0; k < WIN - 1; k++) begin
                for (int i = 1; i < IMG_W; i++) begin
                    lm_r[k][i] <= lm_r[k][i-1];
                end
            end
        end else begin
            lm_r <= lm_r;
        end
    end

    // Next window: shift every row left, new right column from the memories
    always_comb begin
        win_nxt_s = win_r;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                win_nxt_s[r][c] = win_r[r][c+1];
            end
        end
        // Row r looks WIN-1-r lines back, i.e. memory WIN-1-r (index WIN-2-r).
        for (int r = 0; r < WIN - 1; r++) begin
            win_nxt_s[r][WIN-1] = lm_r[WIN-2-r][IMG_W-1];
        end
        win_nxt_s[WIN-1][WIN-1] = data_in;
    end

    // Window register, not cleared
    always_ff @(posedge clk) begin
        if (accept_s) begin
            win_r <= win_nxt_s;
        end else begin
            win_r <= win_r;
        end
    end

    // Flatten row-major (top-left in MSBs) and zero columns left of the line
    always_comb begin
        win_flat_s = {FLAT_W{1'b0}};
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                if (EDGE_ZERO && ((int'(pix_col_s) + c) < (WIN - 1))) begin
                    win_flat_s[(WIN*WIN-1-(r*WIN+c))*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                end else begin
                    win_flat_s[(WIN*WIN-1-(r*WIN+c))*DATA_W +: DATA_W] = win_nxt_s[r][c];
                end
            end
        end
        center_s = win_flat_s[(WIN*WIN-1-(CTR*WIN+CTR))*DATA_W +: DATA_W];
    end

    // Registered outputs: pulses every cycle, window data only on new windows
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window_out   <= {FLAT_W{1'b0}};
            window_valid <= 1'b0;
            center_out   <= {DATA_W{1'b0}};
            out_row      <= {ROW_W{1'b0}};
            out_col      <= {COL_W{1'b0}};
            frame_done   <= 1'b0;
        end else begin
            window_valid <= valid_s;
            frame_done   <= last_s;
            if (valid_s) begin
                window_out <= win_flat_s;
                center_out <= center_s;
                out_row    <= pix_row_s;
                out_col    <= pix_col_s;
            end else begin
                window_out <= window_out;
                center_out <= center_out;
                out_row    <= out_row;
                out_col    <= out_col;
            end
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_window_buffer
// Directed sequence with random pixel data and random enable gaps, checked
// against a frame-array reference model: every accepted pixel is written to
// img[row][col] and each expected window is read straight out of that array.
// -----------------------------------------------------------------------------
module tb_window_buffer;

    localparam int DW = 8;
    localparam int W  = 3;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int FW = W * W * DW;
`ifdef WINBUF_EDGE_ZERO_EN
    localparam bit EZ       = 1'b1;
    localparam int EXP_WINS = (IH - W + 1) * IW;
`else
    localparam bit EZ       = 1'b0;
    localparam int EXP_WINS = (IH - W + 1) * (IW - W + 1);
`endif

    logic           clk;
    logic           rst_n;
    logic           data_enable;
    logic           sof;
    logic [DW-1:0]  data_in;
    logic [FW-1:0]  window_out;
    logic           window_valid;
    logic [DW-1:0]  center_out;
    logic [2:0]     out_row;
    logic [2:0]     out_col;
    logic           frame_done;

    window_buffer #(.DATA_W(DW), .WIN(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .data_enable  (data_enable),
        .sof          (sof),
        .data_in      (data_in),
        .window_out   (window_out),
        .window_valid (window_valid),
        .center_out   (center_out),
        .out_row      (out_row),
        .out_col      (out_col),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    int            img [IH][IW];
    bit            m_active;
    int            m_r, m_c;
    bit            data_known;
    logic [FW-1:0] e_win;
    logic [DW-1:0] e_ctr;
    int            e_row, e_col;
    int            win_cnt, done_obs, done_exp;
    bit            pat_frame;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: model the cycle, drive inputs, sample #1 after the edge.
    task automatic step(input logic de, input logic s, input logic [DW-1:0] d);
        bit acc, e_valid, e_done;
        int pr, pc, rr, cc, v;
        acc = 1'b0; e_valid = 1'b0; e_done = 1'b0; pr = 0; pc = 0;
        if (!rst_n) begin
            m_active = 1'b0; m_r = 0; m_c = 0; data_known = 1'b1;
            e_win = '0; e_ctr = '0; e_row = 0; e_col = 0;
        end else begin
            acc = de && (s || m_active);
        end
        if (acc) begin
            pr = s ? 0 : m_r;
            pc = s ? 0 : m_c;
            img[pr][pc] = int'(d);
            e_valid = (pr >= W - 1) && (EZ || pc >= W - 1);
            e_done  = !s && pr == IH - 1 && pc == IW - 1;
            if (e_valid) begin
                for (int i = 0; i < W; i++) begin
                    for (int j = 0; j < W; j++) begin
                        rr = pr - (W - 1) + i;
                        cc = pc - (W - 1) + j;
                        v  = (cc < 0) ? 0 : img[rr][cc];
                        e_win[(W*W-1-(i*W+j))*DW +: DW] = DW'(v);
                        if (i == W / 2 && j == W / 2) e_ctr = DW'(v);
                    end
                end
                e_row = pr; e_col = pc; data_known = 1'b1;
            end else begin
                data_known = 1'b0;
            end
            if (e_done) begin
                m_active = 1'b0; m_r = 0; m_c = 0; done_exp++;
            end else begin
                m_active = 1'b1;
                if (pc == IW - 1) begin m_c = 0; m_r = pr + 1; end
                else begin m_c = pc + 1; m_r = pr; end
            end
        end
        data_enable = de; sof = s; data_in = d;
        @(posedge clk);
        #1;
        chk("window_valid", FW'(window_valid), FW'(e_valid));
        chk("frame_done", FW'(frame_done), FW'(e_done));
        if (window_valid) win_cnt++;
        if (frame_done) done_obs++;
        if (data_known) begin
            chk("window_out", window_out, e_win);
            chk("center_out", FW'(center_out), FW'(e_ctr));
            chk("out_row", FW'(out_row), FW'(e_row));
            chk("out_col", FW'(out_col), FW'(e_col));
        end
        if (e_valid && pat_frame && pr == 2 && pc == 2) begin
            chk("first_window", window_out, FW'(72'h000102101112202122));
            chk("first_center", FW'(center_out), FW'(8'h11));
        end
        data_enable = 1'b0; sof = 1'b0;
    endtask

    // mode 0: pattern, continuous; 1: pattern, enable toggling;
    // 2: random data with random gaps. Sends npix pixels, sof on the first.
    task automatic run_frame(input int mode, input int npix);
        logic [DW-1:0] d;
        win_cnt = 0;
        for (int p = 0; p < npix; p++) begin
            if (mode == 1) step(1'b0, 1'b0, 8'(p));
            if (mode == 2 && $urandom_range(0, 2) == 0) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            if (mode == 2) d = 8'($urandom);
            else d = 8'((p / IW) * 16 + (p % IW));
            step(1'b1, p == 0, d);
        end
    endtask

    initial begin
        rst_n = 1'b0; data_enable = 1'b0; sof = 1'b0; data_in = '0;
        m_active = 1'b0; m_r = 0; m_c = 0; data_known = 1'b1;
        e_win = '0; e_ctr = '0; e_row = 0; e_col = 0;
        win_cnt = 0; done_obs = 0; done_exp = 0; pat_frame = 1'b0;

        // reset state
        repeat (3) step(1'b1, 1'b1, 8'h5a);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        // reset in the middle of a frame, then pixels without sof
        run_frame(0, 30);
        rst_n = 1'b0;
        #2;
        chk("reset_window", window_out, '0);
        chk("reset_valid", FW'(window_valid), '0);
        step(1'b1, 1'b0, 8'h33);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom));

        // continuous pattern frame
        pat_frame = 1'b1;
        run_frame(0, IW * IH);
        pat_frame = 1'b0;
        chk("count_continuous", FW'(win_cnt), FW'(EXP_WINS));
        step(1'b0, 1'b0, 8'h00);

        // pixels without sof after frame end: ignored
        win_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom));
        chk("count_idle", FW'(win_cnt), '0);

        // enable toggling every cycle
        run_frame(1, IW * IH);
        chk("count_toggle", FW'(win_cnt), FW'(EXP_WINS));
        step(1'b0, 1'b0, 8'h00);

        // sof at (3,4) aborts the frame, then a full random frame
        run_frame(0, 3 * IW + 4);
        run_frame(2, IW * IH);
        chk("count_restart", FW'(win_cnt), FW'(EXP_WINS));
        step(1'b0, 1'b0, 8'h00);

        // sof on the last pixel position wins over frame completion
        run_frame(2, IW * IH - 1);
        run_frame(2, IW * IH);
        chk("count_last_sof", FW'(win_cnt), FW'(EXP_WINS));
        step(1'b0, 1'b0, 8'h00);

        chk("frame_done_total", FW'(done_obs), FW'(done_exp));
        chk("frame_done_expected", FW'(done_exp), FW'(4));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/window_buffer.md
# window_buffer

Parametrised sliding-window generator for the pattern-recognition datapath. It accepts a raster pixel stream, keeps WIN-1 line memories of IMG_W pixels each, and presents a full WIN x WIN neighbourhood every cycle a valid window exists. It also tracks frame position and flags frame completion. It sits between the pixel source and the recognizer/filter stages, and replaces the fixed 8-bit, 7x7 window unit.

## Interface
- DATA_W, 8: pixel width in bits.
- WIN, 7: window edge; odd, 3..9.
- IMG_W, 640: pixels per line; must be >= WIN.
- IMG_H, 480: lines per frame; must be >= WIN.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_enable  in  1  input pixel valid; accepted on every cycle it is high.
- sof  in  1  start of frame; qualified by data_enable; marks the pixel at (row 0, col 0).
- data_in  in  DATA_W  input pixel.
- window_out  out  WIN*WIN*DATA_W  window, row-major. Row 0 / col 0 (oldest, top-left) is in the MSBs. Newest pixel (bottom-right) is in bits [DATA_W-1:0].
- window_valid  out  1  window_out, center_out and the coordinate outputs are valid this cycle.
- center_out  out  DATA_W  window element (WIN/2, WIN/2).
- out_row  out  $clog2(IMG_H)  row of the bottom-right pixel of the current window.
- out_col  out  $clog2(IMG_W)  column of the bottom-right pixel of the current window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Line memory k (1..WIN-1) is an IMG_W-deep shift register. It advances only on accepted pixels. It is fed by data_in for k=1 and by the output of memory k-1 otherwise.
- The window register is WIN rows x WIN cols. On each accepted pixel every row shifts left by one. The new right column is data_in for row WIN-1 and line memory WIN-1-r output for row r.
- Row and column counters: col increments per accepted pixel. At col = IMG_W-1 it wraps to 0 and row increments.
- FSM states:
  - IDLE: counters held at 0; pixels without sof are ignored (no shift, no count).
  - FILL: row < WIN-1.
  - STREAM: row >= WIN-1.
- FSM transitions:
  - IDLE→FILL on data_enable&sof. That pixel is stored as (0,0).
  - FILL→STREAM when row reaches WIN-1.
  - STREAM→IDLE after the pixel at (IMG_H-1, IMG_W-1) is accepted; frame_done pulses.
  - sof in FILL or STREAM restarts the frame: the pixel becomes (0,0), state goes to FILL, and no frame_done is issued.
- window_valid requires an accepted pixel in STREAM with col >= WIN-1.
- Line memories and window contents are not cleared on sof or reset. They are only guaranteed valid once window_valid rules hold.
- Windows never span two frames.

## Timing
- All outputs are registered. A window is presented exactly 1 cycle after its bottom-right pixel is accepted.
- Outputs are held when no pixel is accepted. window_valid and frame_done are single-cycle pulses.
- No backpressure. Downstream must consume in the cycle window_valid is high.
- While reset is low: all outputs are 0, counters are 0, state is IDLE. Taking reset mid-frame discards the frame; no frame_done is issued.
- If sof coincides with the last pixel position, sof wins: restart, no frame_done.
- Throughput: one window per clock once streaming, with data_enable continuously high.

## Configuration
- WINBUF_EDGE_ZERO_EN defined:
  - window_valid also asserts in STREAM for col < WIN-1.
  - Window columns c with col-(WIN-1-c) < 0 (pixels wrapping from the previous line) are forced to 0 in window_out and center_out.
  - Valid windows per frame: (IMG_H-WIN+1)*IMG_W.
- Not defined: behaviour as in Operation; (IMG_H-WIN+1)*(IMG_W-WIN+1) valid windows per frame.

## Test plan
Default config unless noted: DATA_W=8, WIN=3, IMG_W=8, IMG_H=6, data_in = row*16+col.
- Reset low mid-frame, then high -> all outputs 0. No window_valid until a new sof plus 2 full rows.
- Continuous frame -> first window_valid one cycle after (2,2) is accepted. window_out = {00,01,02,10,11,12,20,21,22}h; center_out=11h; out_row=2, out_col=2. Exactly 24 valid windows.
- Same frame with data_enable toggling every cycle -> identical window sequence and count; outputs hold between accepts.
- Last pixel 57h accepted -> frame_done for one cycle next cycle; state IDLE. Further pixels without sof produce no valid windows and no counter change.
- sof asserted at (3,4) -> counters restart. Next window_valid only after new (2,2). No frame_done for the aborted frame.
- With WINBUF_EDGE_ZERO_EN -> window at (2,0) valid = {0,0,00,0,0,10,0,0,20}h. 32 valid windows per frame.
